// File: rtl/axi_slave_wr_if.sv
// AXI write-channel bundle (AW/W/B) shared by a write master and the axi_slave_wr responder.
interface axi_slave_wr_if #(
  parameter int unsigned ADDR_BITS = 32,
  parameter int unsigned DATA_BITS = 32,
  parameter int unsigned LEN_BITS  = 8,
  parameter int unsigned SIZE_BITS = 3
);
  logic                   aw_valid;
  logic                   aw_ready;
  logic [ADDR_BITS-1:0]   aw_addr;
  logic [LEN_BITS-1:0]    aw_len;
  logic [SIZE_BITS-1:0]   aw_size;
  logic [1:0]             aw_burst;
  logic [3:0]             aw_cache;

  logic                   w_valid;
  logic                   w_ready;
  logic [DATA_BITS-1:0]   w_data;
  logic [DATA_BITS/8-1:0] w_strb;
  logic                   w_last;

  logic                   b_valid;
  logic                   b_ready;
  logic [1:0]             b_resp;

  modport master (
    output aw_valid, aw_addr, aw_len, aw_size, aw_burst, aw_cache,
    output w_valid, w_data, w_strb, w_last,
    output b_ready,
    input  aw_ready, w_ready, b_valid, b_resp
  );

  modport slave (
    input  aw_valid, aw_addr, aw_len, aw_size, aw_burst, aw_cache,
    input  w_valid, w_data, w_strb, w_last,
    input  b_ready,
    output aw_ready, w_ready, b_valid, b_resp
  );
endinterface

// File: rtl/axi_slave_wr.sv
// AXI write responder: one outstanding burst (FIXED/INCR/WRAP) into a byte-strobed word memory,
// with a combinational side read port.
module axi_slave_wr #(
  parameter int unsigned ADDR_BITS = 32,
  parameter int unsigned DATA_BITS = 32,
  parameter int unsigned LEN_BITS  = 8,
  parameter int unsigned SIZE_BITS = 3,
  parameter int unsigned MEM_DEPTH = 256,
  localparam int unsigned STRB     = DATA_BITS / 8,
  localparam int unsigned WB       = $clog2(STRB),
  localparam int unsigned IDX      = $clog2(MEM_DEPTH)
) (
  input  logic                 aclk,
  input  logic                 areset,
  axi_slave_wr_if.slave        bus,
  input  logic [IDX-1:0]       dbg_rd_addr,
  output logic [DATA_BITS-1:0] dbg_rd_data
);

  typedef enum logic [1:0] {StIdle, StData, StResp} state_e;

  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstIncr  = 2'b01;
  localparam logic [1:0] BurstWrap  = 2'b10;
  localparam logic [1:0] BurstRsvd  = 2'b11;
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  state_e               state_q, state_d;
  logic                 aw_ready_q, aw_ready_d;
  logic                 w_ready_q, w_ready_d;
  logic                 b_valid_q, b_valid_d;
  logic [1:0]           b_resp_q, b_resp_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [LEN_BITS-1:0]  len_q, len_d;
  logic [SIZE_BITS-1:0] size_q, size_d;
  logic [1:0]           burst_q, burst_d;
  logic [LEN_BITS:0]    cnt_q, cnt_d;
  logic                 err_q, err_d;

  logic [DATA_BITS-1:0] mem [MEM_DEPTH];

  logic [ADDR_BITS-1:0] aw_bytes;
  logic                 cfg_err;
  logic [ADDR_BITS-1:0] bytes;
  logic [ADDR_BITS-1:0] wrap_mask;
  logic [ADDR_BITS-1:0] next_addr;
  logic                 beat;
  logic                 final_beat;
  logic                 beat_err;
  logic                 wr_en;
  logic [IDX-1:0]       widx;
  logic                 unused_cache;

  assign unused_cache = ^bus.aw_cache;

  // Config checks on the incoming AW; any hit suppresses every beat of the burst.
  always_comb begin
    aw_bytes = ADDR_BITS'(1) << bus.aw_size;
    cfg_err  = 1'b0;
    if (bus.aw_burst == BurstRsvd) cfg_err = 1'b1;
    if (bus.aw_size > SIZE_BITS'(WB)) cfg_err = 1'b1;
    if (bus.aw_burst == BurstWrap &&
        bus.aw_len != LEN_BITS'(1) && bus.aw_len != LEN_BITS'(3) &&
        bus.aw_len != LEN_BITS'(7) && bus.aw_len != LEN_BITS'(15)) cfg_err = 1'b1;
    if ((bus.aw_burst == BurstIncr || bus.aw_burst == BurstWrap) &&
        |(bus.aw_addr & (aw_bytes - ADDR_BITS'(1)))) cfg_err = 1'b1;
  end

  always_comb begin
    bytes     = ADDR_BITS'(1) << size_q;
    wrap_mask = bytes * (ADDR_BITS'(len_q) + ADDR_BITS'(1)) - ADDR_BITS'(1);
    case (burst_q)
      BurstIncr: next_addr = addr_q + bytes;
      BurstWrap: next_addr = (addr_q & ~wrap_mask) | ((addr_q + bytes) & wrap_mask);
      default:   next_addr = addr_q;
    endcase
  end

  // w_last mismatch poisons the current beat as well as the rest of the burst.
  assign beat       = (state_q == StData) && bus.w_valid && w_ready_q;
  assign final_beat = (cnt_q == {1'b0, len_q});
  assign beat_err   = (bus.w_last != final_beat);
  assign wr_en      = beat && !(err_q || beat_err);
  assign widx       = addr_q[WB+IDX-1:WB];

  always_comb begin
    state_d    = state_q;
    aw_ready_d = aw_ready_q;
    w_ready_d  = w_ready_q;
    b_valid_d  = b_valid_q;
    b_resp_d   = b_resp_q;
    addr_d     = addr_q;
    len_d      = len_q;
    size_d     = size_q;
    burst_d    = burst_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    unique case (state_q)
      StIdle: begin
        aw_ready_d = 1'b1;
        if (bus.aw_valid && aw_ready_q) begin
          addr_d     = bus.aw_addr;
          len_d      = bus.aw_len;
          size_d     = bus.aw_size;
          burst_d    = bus.aw_burst;
          cnt_d      = '0;
          err_d      = cfg_err;
          aw_ready_d = 1'b0;
          w_ready_d  = 1'b1;
          state_d    = StData;
        end
      end
      StData: begin
        if (beat) begin
          cnt_d  = cnt_q + {{LEN_BITS{1'b0}}, 1'b1};
          err_d  = err_q | beat_err;
          addr_d = next_addr;
          if (final_beat) begin
            w_ready_d = 1'b0;
            b_valid_d = 1'b1;
            b_resp_d  = (err_q | beat_err) ? RespSlvErr : RespOkay;
            state_d   = StResp;
          end
        end
      end
      StResp: begin
        if (b_valid_q && bus.b_ready) begin
          b_valid_d  = 1'b0;
          b_resp_d   = RespOkay;
          aw_ready_d = 1'b1;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q    <= StIdle;
      aw_ready_q <= 1'b0;
      w_ready_q  <= 1'b0;
      b_valid_q  <= 1'b0;
      b_resp_q   <= RespOkay;
      addr_q     <= '0;
      len_q      <= '0;
      size_q     <= '0;
      burst_q    <= BurstFixed;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      aw_ready_q <= aw_ready_d;
      w_ready_q  <= w_ready_d;
      b_valid_q  <= b_valid_d;
      b_resp_q   <= b_resp_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      size_q     <= size_d;
      burst_q    <= burst_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  // Memory survives reset by design.
  always_ff @(posedge aclk) begin
    if (wr_en) begin
      for (int k = 0; k < STRB; k++) begin
        if (bus.w_strb[k]) mem[widx][8*k +: 8] <= bus.w_data[8*k +: 8];
      end
    end
  end

  assign dbg_rd_data  = mem[dbg_rd_addr];
  assign bus.aw_ready = aw_ready_q;
  assign bus.w_ready  = w_ready_q;
  assign bus.b_valid  = b_valid_q;
  assign bus.b_resp   = b_resp_q;

endmodule

// File: tb/tb_axi_slave_wr.sv
// Directed and randomized bursts against a word-array reference model of the write responder.
module tb_axi_slave_wr;
  localparam int unsigned DEPTH = 256;

  logic        aclk = 1'b0;
  logic        areset;
  logic [7:0]  dbg_rd_addr;
  logic [31:0] dbg_rd_data;

  axi_slave_wr_if bus ();

  axi_slave_wr dut (
    .aclk        (aclk),
    .areset      (areset),
    .bus         (bus),
    .dbg_rd_addr (dbg_rd_addr),
    .dbg_rd_data (dbg_rd_data)
  );

  always #5 aclk = ~aclk;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] mdl [DEPTH];
  logic [31:0] bd  [256];
  logic [3:0]  bs  [256];
  logic        bl  [256];
  int          wrap_lens [4] = '{1, 3, 7, 15};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  function automatic int unsigned beat_addr(int unsigned addr, int unsigned len,
                                            int unsigned size, logic [1:0] bt, int unsigned i);
    int unsigned bytes = 1 << size;
    int unsigned bound = bytes * (len + 1);
    int unsigned base  = addr - (addr % bound);
    case (bt)
      2'b01:   return addr + i * bytes;
      2'b10:   return base + ((addr - base + i * bytes) % bound);
      default: return addr;
    endcase
  endfunction

  function automatic bit cfg_error(int unsigned addr, int unsigned len, int unsigned size,
                                   logic [1:0] bt);
    int unsigned bytes = 1 << size;
    if (bt == 2'b11 || size > 2) return 1'b1;
    if (bt == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15)) return 1'b1;
    if (bt != 2'b00 && (addr % bytes) != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic fill(input int len);
    for (int i = 0; i <= len; i++) begin
      bd[i] = $urandom;
      bs[i] = 4'hF;
      bl[i] = (i == len);
    end
  endtask

  task automatic peek(input int idx, input logic [31:0] exp);
    dbg_rd_addr = 8'(idx);
    #1;
    check($sformatf("peek_mem[%0d]", idx), dbg_rd_data, exp);
  endtask

  task automatic sweep();
    for (int w = 0; w < DEPTH; w++) begin
      dbg_rd_addr = 8'(w);
      #1;
      check($sformatf("mem[%0d]", w), dbg_rd_data, mdl[w]);
    end
  endtask

  // abort_beat >= 0 pulses areset while that beat is on the bus and leaves the burst unfinished.
  task automatic run_burst(input int unsigned addr, input int len, input int size,
                           input logic [1:0] bt, input int gap_pct, input int bwait,
                           input int abort_beat);
    int          n;
    bit          err;
    int unsigned a;
    int          w;
    logic [1:0]  exp_resp;
    n = 0;
    while (bus.aw_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("aw_ready_idle", bus.aw_ready, 1'b1);
    check("w_ready_idle", bus.w_ready, 1'b0);
    bus.aw_valid = 1'b1;
    bus.aw_addr  = addr;
    bus.aw_len   = 8'(len);
    bus.aw_size  = 3'(size);
    bus.aw_burst = bt;
    bus.aw_cache = 4'($urandom);
    tick();
    bus.aw_valid = 1'b0;
    check("aw_ready_data", bus.aw_ready, 1'b0);
    check("w_ready_data", bus.w_ready, 1'b1);
    err = cfg_error(addr, len, size, bt);
    for (int i = 0; i <= len; i++) begin
      while ($urandom_range(99) < gap_pct) begin
        bus.w_valid = 1'b0;
        bus.w_data  = $urandom;
        bus.w_strb  = 4'hF;
        tick();
        check("gap_hold", {bus.w_ready, bus.b_valid, bus.aw_ready}, 3'b100);
      end
      bus.w_valid = 1'b1;
      bus.w_data  = bd[i];
      bus.w_strb  = bs[i];
      bus.w_last  = bl[i];
      if (i == abort_beat) begin
        #2;
        areset = 1'b1;
        #1;
        check("reset_mid_burst",
              {bus.aw_ready, bus.w_ready, bus.b_valid, bus.b_resp}, 5'b0);
        bus.w_valid = 1'b0;
        tick();
        areset = 1'b0;
        return;
      end
      tick();
      if (bl[i] != (i == len)) err = 1'b1;
      if (!err) begin
        a = beat_addr(addr, len, size, bt, i);
        w = int'((a >> 2) % DEPTH);
        for (int k = 0; k < 4; k++) if (bs[i][k]) mdl[w][8*k +: 8] = bd[i][8*k +: 8];
      end
      if (i < len) check("mid_burst", {bus.w_ready, bus.b_valid}, 2'b10);
    end
    bus.w_valid = 1'b0;
    bus.w_last  = 1'b0;
    exp_resp = err ? 2'b10 : 2'b00;
    check("b_valid_after_last", bus.b_valid, 1'b1);
    check("b_resp", bus.b_resp, exp_resp);
    check("w_ready_resp", bus.w_ready, 1'b0);
    for (int j = 0; j < bwait; j++) begin
      tick();
      check("b_hold", {bus.b_valid, bus.b_resp, bus.aw_ready}, {1'b1, exp_resp, 1'b0});
    end
    bus.b_ready = 1'b1;
    tick();
    bus.b_ready = 1'b0;
    check("b_done", {bus.b_valid, bus.aw_ready}, 2'b01);
  endtask

  initial begin
    int unsigned addr;
    int          len;
    int          size;
    logic [1:0]  bt;

    bus.aw_valid = 1'b0; bus.aw_addr = '0; bus.aw_len = '0; bus.aw_size = '0;
    bus.aw_burst = '0;   bus.aw_cache = '0;
    bus.w_valid  = 1'b0; bus.w_data = '0; bus.w_strb = '0; bus.w_last = 1'b0;
    bus.b_ready  = 1'b0;
    dbg_rd_addr  = '0;
    areset       = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    areset = 1'b0;
    check("reset_outputs", {bus.aw_ready, bus.w_ready, bus.b_valid, bus.b_resp}, 5'b0);
    tick();
    check("aw_ready_after_reset", bus.aw_ready, 1'b1);

    // Known memory contents first, so the sweep has a defined reference everywhere.
    fill(255);
    run_burst(0, 255, 2, 2'b01, 0, 0, -1);
    sweep();

    // INCR
    fill(3);
    for (int i = 0; i < 4; i++) bd[i] = 32'hA0 + 32'(i);
    run_burst(32'h10, 3, 2, 2'b01, 0, 0, -1);
    peek(4, 32'hA0); peek(5, 32'hA1); peek(6, 32'hA2); peek(7, 32'hA3);

    // FIXED with strobes
    fill(1);
    bd[0] = 32'h1122_3344; bs[0] = 4'hF;
    bd[1] = 32'hAABB_CCDD; bs[1] = 4'h3;
    run_burst(32'h20, 1, 2, 2'b00, 0, 0, -1);
    peek(8, 32'h1122_CCDD);

    // WRAP
    fill(3);
    for (int i = 0; i < 4; i++) bd[i] = 32'hB0 + 32'(i);
    run_burst(32'h08, 3, 2, 2'b10, 0, 0, -1);
    peek(2, 32'hB0); peek(3, 32'hB1); peek(0, 32'hB2); peek(1, 32'hB3);

    // Early w_last: only the first beat lands
    fill(3);
    for (int i = 0; i < 4; i++) bd[i] = 32'hC0 + 32'(i);
    bl[1] = 1'b1;
    run_burst(32'h40, 3, 2, 2'b01, 0, 0, -1);
    peek(16, 32'hC0);
    sweep();

    // Reserved burst type
    fill(1);
    run_burst(32'h50, 1, 2, 2'b11, 0, 0, -1);
    sweep();

    // W offered while idle must be ignored, then a burst under backpressure
    bus.w_valid = 1'b1; bus.w_data = 32'hDEAD_BEEF; bus.w_strb = 4'hF; bus.w_last = 1'b1;
    tick();
    check("w_ready_idle_offer", bus.w_ready, 1'b0);
    tick();
    bus.w_valid = 1'b0; bus.w_last = 1'b0;
    fill(3);
    run_burst(32'h80, 3, 2, 2'b01, 60, 5, -1);
    sweep();

    // Reset during beat 2 of 4, then a clean burst
    fill(3);
    for (int i = 0; i < 4; i++) bd[i] = 32'hE0 + 32'(i);
    run_burst(32'h60, 3, 2, 2'b01, 0, 0, 1);
    peek(24, 32'hE0);
    fill(3);
    run_burst(32'h90, 3, 2, 2'b01, 0, 0, -1);
    sweep();

    for (int r = 0; r < 12; r++) begin
      bt   = ($urandom_range(9) == 0) ? 2'b11 : 2'($urandom_range(2));
      size = ($urandom_range(9) == 0) ? 3 : int'($urandom_range(2));
      if (bt == 2'b10) len = ($urandom_range(9) == 0) ? 2 : wrap_lens[$urandom_range(3)];
      else len = int'($urandom_range(7));
      addr = $urandom_range(1023);
      if ($urandom_range(4) != 0) addr = addr & ~((32'd1 << size) - 1);
      for (int i = 0; i <= len; i++) begin
        bd[i] = $urandom;
        bs[i] = 4'($urandom);
        bl[i] = (i == len) ^ ($urandom_range(9) == 0);
      end
      run_burst(addr, len, size, bt, 30, int'($urandom_range(3)), -1);
      sweep();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

endmodule
